// File: rtl/gpio_irq_ctrl_if.sv
// CPU-side register and interrupt bus of gpio_irq_ctrl.
// Master is the CPU/bench, slave is the controller.
interface gpio_irq_ctrl_if #(
  parameter int DW  = 8,
  parameter int IDW = 3
);
  logic [2:0]     addr_i;
  logic           wen_i;
  logic           ren_i;
  logic [DW-1:0]  wdata_i;
  logic [DW-1:0]  rdata_o;
  logic           irq_o;
  logic [IDW-1:0] irq_id_o;
  logic           irq_ack_i;

  modport master (
    output addr_i, wen_i, ren_i, wdata_i, irq_ack_i,
    input  rdata_o, irq_o, irq_id_o
  );

  modport slave (
    input  addr_i, wen_i, ren_i, wdata_i, irq_ack_i,
    output rdata_o, irq_o, irq_id_o
  );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: 2-flop sync, level/edge detect, sticky status, fixed-priority IRQ FSM.
// Latency: pin to irq_o 4 cycles, read data 1 cycle after ren_i; no backpressure, CPU acks each IRQ.
module gpio_irq_ctrl #(
  parameter int DW  = 8,
  parameter int IDW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] gpio_i,
  gpio_irq_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  logic [DW-1:0]  meta_q, sync_q, prev_q;
  logic [DW-1:0]  ie_q, type_q, pol_q, status_q;
  logic [DW-1:0]  evt, pending, clr, vec, rd_mux, rdata_q;
  logic [1:0]     state_q;
  logic [IDW-1:0] id_q, sel;
  logic           any_pending, ack_hit;

  // Level: pin equals polarity. Edge: pol=1 rising, pol=0 falling.
  assign evt = (~type_q & ~(sync_q ^ pol_q))
             | ( type_q &  pol_q &  sync_q & ~prev_q)
             | ( type_q & ~pol_q & ~sync_q &  prev_q);

  assign pending     = status_q & ie_q;
  assign any_pending = |pending;
  assign ack_hit     = (state_q == ST_ASSERT) && bus.irq_ack_i;

  always_comb begin
    sel = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (pending[i]) sel = IDW'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (bus.wen_i && (bus.addr_i == 3'd3)) clr = bus.wdata_i;
    if (ack_hit) clr[id_q] = 1'b1;
  end

  always_comb begin
    vec           = '0;
    vec[IDW-1:0]  = sel;
    vec[DW-1]     = any_pending;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr_i)
      3'd0:    rd_mux = ie_q;
      3'd1:    rd_mux = type_q;
      3'd2:    rd_mux = pol_q;
      3'd3:    rd_mux = status_q;
      3'd4:    rd_mux = sync_q;
      3'd5:    rd_mux = vec;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      status_q <= '0;
      ie_q     <= '0;
      type_q   <= '0;
      pol_q    <= '0;
      rdata_q  <= '0;
    end else begin
      meta_q   <= gpio_i;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      // A new event wins over a same-cycle clear.
      status_q <= (status_q & ~clr) | evt;
      if (bus.wen_i) begin
        case (bus.addr_i)
          3'd0:    ie_q   <= bus.wdata_i;
          3'd1:    type_q <= bus.wdata_i;
          3'd2:    pol_q  <= bus.wdata_i;
          default: ;
        endcase
      end
      if (bus.ren_i) rdata_q <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_pending) begin
            id_q    <= sel;
            state_q <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (bus.irq_ack_i)        state_q <= ST_GAP;
          else if (!pending[id_q])  state_q <= ST_IDLE;
        end
        ST_GAP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.irq_o    = (state_q == ST_ASSERT);
  assign bus.irq_id_o = id_q;
  assign bus.rdata_o  = rdata_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_gpio_irq_ctrl;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pins;
  int         n_vec = 0;
  int         n_bad = 0;

  gpio_irq_ctrl_if #(.DW(8), .IDW(3)) bus ();

  gpio_irq_ctrl #(.DW(8), .IDW(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .gpio_i (pins),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model state: register contents, pin history (newest first), interrupt phase.
  int unsigned m_ie, m_type, m_pol, m_stat, m_rd, m_id;
  bit          m_irq, m_gap;
  int unsigned hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lowest(input int unsigned v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input bit rs, input int unsigned g, input int unsigned a,
                            input bit w, input bit r, input int unsigned wd, input bit ack);
    int unsigned sync, prev, evt, pend, clr, vec;
    bit s, p, pl;
    if (rs) begin
      m_ie = 0; m_type = 0; m_pol = 0; m_stat = 0; m_rd = 0; m_id = 0;
      m_irq = 0; m_gap = 0;
      hist = '{0, 0, 0};
      return;
    end
    sync = hist[1];
    prev = hist[2];
    evt  = 0;
    for (int i = 0; i < DW; i++) begin
      s  = sync[i];
      p  = prev[i];
      pl = m_pol[i];
      if (!m_type[i]) evt[i] = (s == pl);
      else            evt[i] = pl ? (s && !p) : (!s && p);
    end
    pend = m_stat & m_ie;
    vec  = (pend != 0) ? (32'h80 | lowest(pend)) : 0;
    if (r) begin
      case (a)
        0: m_rd = m_ie;
        1: m_rd = m_type;
        2: m_rd = m_pol;
        3: m_rd = m_stat;
        4: m_rd = sync;
        5: m_rd = vec;
        default: m_rd = 0;
      endcase
    end
    clr = (w && a == 3) ? wd : 0;
    if (m_irq) begin
      if (ack) begin
        clr  |= (1 << m_id);
        m_irq = 0;
        m_gap = 1;
      end else if (!pend[m_id]) begin
        m_irq = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (pend != 0) begin
      m_irq = 1;
      m_id  = lowest(pend);
    end
    m_stat = ((m_stat & ~clr) | evt) & 32'hFF;
    if (w) begin
      case (a)
        0: m_ie   = wd;
        1: m_type = wd;
        2: m_pol  = wd;
        default: ;
      endcase
    end
    hist.push_front(g);
    void'(hist.pop_back());
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit rs, input int unsigned a, input bit w, input bit r,
                       input int unsigned wd, input bit ack);
    rst           = rs;
    bus.addr_i    = a[2:0];
    bus.wen_i     = w;
    bus.ren_i     = r;
    bus.wdata_i   = wd[7:0];
    bus.irq_ack_i = ack;
    model_step(rs, {24'd0, pins}, a, w, r, wd, ack);
    @(negedge clk);
    chk("irq", {31'd0, bus.irq_o}, {31'd0, m_irq});
    if (m_irq) chk("irq_id", {29'd0, bus.irq_id_o}, m_id);
    if (r || rs) chk("rdata", {24'd0, bus.rdata_o}, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int unsigned a, input int unsigned d);
    cycle(0, a, 1, 0, d, 0);
  endtask

  task automatic rd(input int unsigned a, output logic [7:0] v);
    cycle(0, a, 0, 1, 0, 0);
    v = bus.rdata_o;
  endtask

  task automatic ack();
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic wait_irq(input int max);
    int n;
    n = 0;
    while (!bus.irq_o && n < max) begin
      idle(1);
      n++;
    end
    if (!bus.irq_o) chk("irq_timeout", 0, 1);
  endtask

  task automatic config_ctrl(input int unsigned ie, input int unsigned typ, input int unsigned pol);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    wr(1, typ);
    wr(2, pol);
    idle(3);
    wr(3, 8'hFF);
    wr(0, ie);
  endtask

  logic [7:0] v;

  initial begin
    rst = 1'b1; pins = 8'h00;
    bus.addr_i = 3'd0; bus.wen_i = 1'b0; bus.ren_i = 1'b0;
    bus.wdata_i = 8'h00; bus.irq_ack_i = 1'b0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_irq", {31'd0, bus.irq_o}, 0);
    rd(3, v); chk("rst_stat", {24'd0, v}, 0);

    // Single rising edge on pin 0: 4-cycle latency, ack, gap, quiet.
    pins = 8'h00;
    config_ctrl(8'h01, 8'hFF, 8'hFF);
    idle(2);
    chk("t1_idle", {31'd0, bus.irq_o}, 0);
    pins = 8'h01;
    idle(3);
    chk("t1_lat3", {31'd0, bus.irq_o}, 0);
    idle(1);
    chk("t1_lat4", {31'd0, bus.irq_o}, 1);
    chk("t1_id", {29'd0, bus.irq_id_o}, 0);
    ack();
    chk("t1_gap", {31'd0, bus.irq_o}, 0);
    rd(3, v); chk("t1_stat", {24'd0, v}, 0);
    idle(3);
    chk("t1_quiet", {31'd0, bus.irq_o}, 0);

    // Simultaneous edges on pins 5 and 2: priority to 2, then 5.
    pins = 8'h00;
    config_ctrl(8'hFF, 8'hFF, 8'hFF);
    idle(2);
    pins = 8'h24;
    idle(4);
    chk("t2_irq", {31'd0, bus.irq_o}, 1);
    chk("t2_id2", {29'd0, bus.irq_id_o}, 2);
    ack();
    idle(1);
    chk("t2_idle", {31'd0, bus.irq_o}, 0);
    idle(1);
    chk("t2_irq5", {31'd0, bus.irq_o}, 1);
    chk("t2_id5", {29'd0, bus.irq_id_o}, 5);
    ack();
    idle(3);
    chk("t2_quiet", {31'd0, bus.irq_o}, 0);

    // W1C without ack drops the request.
    pins = 8'h00;
    config_ctrl(8'hFF, 8'hFF, 8'hFF);
    pins = 8'h08;
    idle(4);
    chk("t3_id", {29'd0, bus.irq_id_o}, 3);
    wr(3, 8'h08);
    idle(1);
    chk("t3_drop", {31'd0, bus.irq_o}, 0);
    idle(4);
    chk("t3_quiet", {31'd0, bus.irq_o}, 0);
    rd(5, v); chk("t3_vec", {24'd0, v}, 0);

    // Active-low level on pin 1: reasserts after every ack until released.
    pins = 8'hFD;
    config_ctrl(8'h02, 8'hFD, 8'h00);
    wait_irq(6);
    chk("t4_id", {29'd0, bus.irq_id_o}, 1);
    for (int k = 0; k < 3; k++) begin
      ack();
      chk("t4_gap", {31'd0, bus.irq_o}, 0);
      idle(2);
      chk("t4_reassert", {31'd0, bus.irq_o}, 1);
    end
    pins = 8'hFF;
    idle(4);
    chk("t4_held", {31'd0, bus.irq_o}, 1);
    ack();
    idle(4);
    chk("t4_released", {31'd0, bus.irq_o}, 0);
    rd(3, v); chk("t4_stat", {24'd0, v}, 0);

    // Edge and W1C in the same cycle keep the bit; IE=0 never interrupts.
    pins = 8'h00;
    config_ctrl(8'h7F, 8'hFF, 8'hFF);
    pins = 8'h80;
    idle(2);
    wr(3, 8'h80);
    rd(3, v); chk("t5_stat", {24'd0, v}, 8'h80);
    chk("t5_noirq", {31'd0, bus.irq_o}, 0);
    rd(5, v); chk("t5_vec", {24'd0, v}, 0);

    // Reset while asserted.
    pins = 8'h00;
    config_ctrl(8'hFF, 8'hFF, 8'hFF);
    pins = 8'h01;
    wait_irq(8);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t6_irq", {31'd0, bus.irq_o}, 0);
    chk("t6_rdata", {24'd0, bus.rdata_o}, 0);
    rd(3, v); chk("t6_stat", {24'd0, v}, 0);
    rd(0, v); chk("t6_ie", {24'd0, v}, 0);
    rd(1, v); chk("t6_type", {24'd0, v}, 0);
    rd(2, v); chk("t6_pol", {24'd0, v}, 0);

    // Random traffic.
    cycle(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) pins = 8'($urandom);
      cycle($urandom_range(0, 299) == 0,
            ($urandom_range(0, 2) == 0) ? 3 : $urandom_range(0, 7),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0,
            $urandom & 32'hFF,
            $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want finish before time limit");
    $fatal(1);
  end
endmodule

// File: doc/gpio_irq_ctrl.md
GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 Parameter DW, default 8, number of GPIO pins (1..32).
REQ-002 Parameter IDW, default 3, width of interrupt index, equals ceil(log2(DW)) with a minimum of 1.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 gpio_i  in  DW  asynchronous pin inputs.
REQ-006 addr_i  in  3  register select.
REQ-007 wen_i  in  1  register write strobe, one cycle.
REQ-008 ren_i  in  1  register read strobe, one cycle.
REQ-009 wdata_i  in  DW  write data.
REQ-010 rdata_o  out  DW  read data, valid the cycle after ren_i.
REQ-011 irq_o  out  1  interrupt request to the CPU.
REQ-012 irq_id_o  out  IDW  index of the pin being signalled; valid while irq_o=1.
REQ-013 irq_ack_i  in  1  CPU acknowledge pulse for the current irq_id_o.

Function
REQ-014 gpio_i SHALL pass through a 2-flop synchronizer; sync and prev (one cycle older) registers feed detection.
REQ-015 Per pin, type=0 (level) SHALL give evt = (sync==pol); type=1 (edge) SHALL give evt = rising (pol=1) or falling (pol=0) on sync vs prev.
REQ-016 Register map SHALL be: 0 IE (rw), 1 TYPE (rw), 2 POL (rw), 3 STATUS (read, write-1-to-clear), 4 PIN (sync value, ro), 5 VEC (ro: bit DW-1 = pending-valid, bits IDW-1:0 = lowest pending enabled index), 6-7 read 0 and writes ignored.
REQ-017 STATUS[i] SHALL set on evt[i] regardless of IE[i].
REQ-018 STATUS[i] SHALL clear on a W1C write bit or an ack of index i; a set and a clear in the same cycle SHALL leave the bit at 1.
REQ-019 pending = STATUS & IE; the selected index SHALL be the lowest set bit of pending (fixed priority, bit 0 highest).
REQ-020 FSM states IDLE, ASSERT, GAP; irq_o=1 only in ASSERT.
REQ-021 IDLE: if pending!=0, latch the selected index into irq_id_o and go to ASSERT next cycle.
REQ-022 ASSERT: irq_id_o SHALL stay stable; on irq_ack_i, clear STATUS[irq_id_o] and go to GAP.
REQ-023 ASSERT: if pending[irq_id_o] drops without ack (W1C or IE cleared), the FSM SHALL go to IDLE with no status change.
REQ-024 GAP SHALL last exactly one cycle with irq_o=0, then go to IDLE.
REQ-025 irq_ack_i outside ASSERT SHALL be ignored.
REQ-026 A level source still active after ack SHALL re-set STATUS the next cycle and re-interrupt via normal flow.
REQ-027 Register writes take effect the cycle after wen_i; wen_i and ren_i to the same address in one cycle SHALL return the pre-write value.

Reset
REQ-028 On rst: IE, TYPE, POL, STATUS, synchronizer, prev = 0; FSM = IDLE; irq_o=0; irq_id_o=0; rdata_o=0.
REQ-029 rst mid-handshake SHALL abort to IDLE with all state cleared; the first evaluation after release uses a 0 prev, so a pin held high with edge/pol=1 SHALL produce one event after sync.

Verification
REQ-030 IE=0x01, TYPE=0x01, POL=0x01, gpio_i[0] 0->1: irq_o rises 4 cycles after the pin change (2 sync + status + IDLE), irq_id_o=0; ack -> STATUS=0x00, irq_o low 1 cycle, stays low.
REQ-031 IE=0xFF, edges on pins 5 and 2 in the same cycle: irq_id_o=2 first; after ack and GAP, irq_id_o=5.
REQ-032 ASSERT on pin 3, write STATUS=0x08 without ack: irq_o drops next cycle, FSM IDLE, no re-assert.
REQ-033 Level pin 1 active-low (TYPE=0, POL=0) held low, ack each time: irq_o reasserts after every GAP; release pin -> ack clears and no reassert.
REQ-034 Edge event and W1C on the same bit in the same cycle: STATUS bit reads 1; IE=0 edge: STATUS sets, irq_o stays 0, VEC valid=0.
REQ-035 rst asserted in ASSERT: next cycle irq_o=0, all registers read 0.
